// File: rtl/float_to_int.sv
// IEEE-754 single-precision to int32 converter, round-to-nearest-even.
// Specials and out-of-range operands resolve in one cycle; others align serially, then round.
module float_to_int (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] c,
    output logic        invalid,
    output logic        inexact
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ALIGN = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0] ALIGN_EXP = 8'd150;

    logic [1:0]  state_r;
    logic [33:0] work_r;
    logic [7:0]  cnt_r;
    logic        sign_r;
    logic        out_valid_r;
    logic [31:0] c_r;
    logic        invalid_r;
    logic        inexact_r;

    logic [7:0]  exp_s;
    logic [22:0] man_s;
    logic        fast_s;
    logic [31:0] fast_c_s;
    logic        fast_invalid_s;
    logic        fast_inexact_s;
    logic        round_inc_s;
    logic [31:0] mag_s;
    logic [31:0] res_s;

    assign exp_s     = a[30:23];
    assign man_s     = a[22:0];
    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign c         = c_r;
    assign invalid   = invalid_r;
    assign inexact   = inexact_r;

    // Classify the operand for one-cycle resolution (specials, saturation, |a| < 0.5).
    always_comb begin
        fast_s         = 1'b0;
        fast_c_s       = 32'd0;
        fast_invalid_s = 1'b0;
        fast_inexact_s = 1'b0;
        if (exp_s == 8'd255) begin
            fast_s         = 1'b1;
            fast_invalid_s = 1'b1;
            if ((man_s != 23'd0) || (a[31] == 1'b0)) begin
                fast_c_s = 32'h7FFF_FFFF;
            end else begin
                fast_c_s = 32'h8000_0000;
            end
        end else if (exp_s >= 8'd158) begin
            fast_s = 1'b1;
            if (a[31] == 1'b0) begin
                fast_c_s       = 32'h7FFF_FFFF;
                fast_invalid_s = 1'b1;
            end else begin
                fast_c_s       = 32'h8000_0000;
                // -2^31 is exactly representable
                fast_invalid_s = (a != 32'hCF00_0000);
            end
        end else if (exp_s < 8'd126) begin
            fast_s         = 1'b1;
            fast_c_s       = 32'd0;
            fast_inexact_s = (a[30:0] != 31'd0);
        end else begin
            fast_s = 1'b0;
        end
    end

    // Round half to even on the aligned integer/guard/sticky bits, then apply sign.
    always_comb begin
        round_inc_s = work_r[1] & (work_r[0] | work_r[2]);
        mag_s       = work_r[33:2] + {31'd0, round_inc_s};
        if (sign_r) begin
            res_s = 32'd0 - mag_s;
        end else begin
            res_s = mag_s;
        end
    end

    // Control FSM, alignment datapath and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            work_r      <= 34'd0;
            cnt_r       <= 8'd0;
            sign_r      <= 1'b0;
            out_valid_r <= 1'b0;
            c_r         <= 32'd0;
            invalid_r   <= 1'b0;
            inexact_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        if (fast_s) begin
                            c_r         <= fast_c_s;
                            invalid_r   <= fast_invalid_s;
                            inexact_r   <= fast_inexact_s;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            work_r  <= {8'd0, 1'b1, man_s, 2'b00};
                            cnt_r   <= exp_s;
                            sign_r  <= a[31];
                            state_r <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (cnt_r > ALIGN_EXP) begin
                        work_r <= {work_r[32:0], 1'b0};
                        cnt_r  <= cnt_r - 8'd1;
                    end else if (cnt_r < ALIGN_EXP) begin
                        // guard shifts into sticky, which accumulates
                        work_r <= {1'b0, work_r[33:2], work_r[1] | work_r[0]};
                        cnt_r  <= cnt_r + 8'd1;
                    end else begin
                        state_r <= ROUND;
                    end
                end
                ROUND: begin
                    c_r         <= res_s;
                    invalid_r   <= 1'b0;
                    inexact_r   <= work_r[1] | work_r[0];
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int.sv
// Randomized self-checking bench for float_to_int against a real-arithmetic reference.
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic        invalid;
    logic        inexact;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    float_to_int dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .invalid   (invalid),
        .inexact   (inexact)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: decode the float to its exact real value, round half-even, saturate.
    task automatic ref_model(input logic [31:0] x, output logic [31:0] ec,
                             output logic ei, output logic ex, output int lat);
        int     e;
        int     sc;
        logic   neg;
        real    v;
        real    fr;
        longint fl;
        e   = int'(x[30:23]);
        neg = x[31];
        ei  = 1'b0;
        ex  = 1'b0;
        ec  = 32'd0;
        if (e >= 126 && e <= 157) lat = 3 + ((e > 150) ? (e - 150) : (150 - e));
        else lat = 1;
        if (e == 255) begin
            ei = 1'b1;
            ec = (x[22:0] != 23'd0 || !neg) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else begin
            if (e == 0) begin
                v  = real'(x[22:0]);
                sc = -149;
            end else begin
                v  = real'(x[22:0]) + 8388608.0;
                sc = e - 150;
            end
            for (int i = 0; i < sc; i++) v = v * 2.0;
            for (int i = 0; i < -sc; i++) v = v / 2.0;
            if (v >= 2147483648.0) begin
                if (neg && v == 2147483648.0) ec = 32'h8000_0000;
                else begin
                    ei = 1'b1;
                    ec = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
                end
            end else begin
                fl = longint'(v);
                if (real'(fl) > v) fl = fl - 64'sd1;
                fr = v - real'(fl);
                if (fr > 0.5 || (fr == 0.5 && fl[0])) fl = fl + 64'sd1;
                ex = (real'(fl) != v);
                if (neg) fl = -fl;
                ec = fl[31:0];
            end
        end
    endtask

    task automatic run_op(input logic [31:0] x, input int hold);
        logic [31:0] ec;
        logic        ei;
        logic        ex;
        int          lat;
        int          n;
        ref_model(x, ec, ei, ex, lat);
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq($sformatf("latency a=%h", x), 32'(n), 32'(lat));
        check_eq($sformatf("c a=%h", x), c, ec);
        check_eq($sformatf("invalid a=%h", x), 32'(invalid), 32'(ei));
        check_eq($sformatf("inexact a=%h", x), 32'(inexact), 32'(ex));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            @(posedge clk); #1;
            check_eq("hold_c", c, ec);
            check_eq("hold_flags", {30'd0, invalid, inexact}, {30'd0, ei, ex});
            check_eq("hold_out_valid", 32'(out_valid), 32'd1);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("release_out_valid", 32'(out_valid), 32'd0);
        check_eq("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    logic [31:0] directed [0:13] = '{
        32'h4B00_0001, 32'h3FC0_0000, 32'h4020_0000, 32'hC020_0000,
        32'h3F00_0000, 32'h4049_0FDB, 32'h7FC0_0000, 32'h4F00_0000,
        32'hCF00_0000, 32'h8000_0000, 32'hFF80_0000, 32'h7F80_0000,
        32'h0000_0001, 32'h4EFF_FFFF
    };

    initial begin
        logic [31:0] r;
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 32'h4B00_0001;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check_eq("reset_in_ready", 32'(in_ready), 32'd1);
        check_eq("reset_out_valid", 32'(out_valid), 32'd0);
        check_eq("reset_c", c, 32'd0);
        check_eq("reset_flags", {30'd0, invalid, inexact}, 32'd0);

        foreach (directed[i]) run_op(directed[i], 0);
        run_op(32'h4049_0FDB, 5);

        // Reset in the middle of a long alignment, with a competing in_valid.
        in_valid = 1'b1;
        a        = 32'h3F00_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h3FC0_0000;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_c", c, 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        run_op(32'hC020_0000, 0);

        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            if (k % 2 == 0) r[30:23] = 8'($urandom_range(118, 160));
            run_op(r, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
